time_date_counter: RTL and testbench

Time-of-day and calendar counter that produces the hour, minute, second, day, month and year values consumed by LCD_Display, plus the PM flag for the AM/PM indicator. An internal prescaler divides the system clock down to a 1 Hz tick. Values can be set through a single-cycle load port with range checking. 12/24-hour display formatting is applied on a separate display-hour output.

---
 rtl/time_date_counter.sv | 184 ++++++++++++++++++
 tb/tb_time_date_counter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_date_counter.sv
// time_date_counter
//   Time-of-day and calendar counter feeding the LCD display. A prescaler
//   divides clk down to a once-per-second tick that advances
//   second -> minute -> hour -> day -> month -> year. All six fields can be
//   replaced with a range-checked, single-cycle load.
//
//   load strobe semantics: load is sampled on every rising edge with no
//   handshake. If the load_* values are all in range, they replace the fields
//   and the prescaler restarts from 0. Otherwise load_err pulses for one
//   cycle and nothing else changes. A load discards any tick that coincides
//   with it.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   run                 1 = prescaler advances, 0 = everything frozen
//   mode_12hr           selects 12-hour formatting on hour_disp / pm
//   load, load_*        single-cycle load strobe and the values to load
//   hour..year          registered time and date fields (year 0..99 = 2000..2099)
//   hour_disp, pm       formatted hour and PM flag (combinational)
//   sec_tick            one-cycle pulse when a new second value appears
//   load_err            one-cycle pulse when a load is rejected
module time_date_counter #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       mode_12hr,
    input  logic       load,
    input  logic [5:0] load_hour,
    input  logic [5:0] load_minute,
    input  logic [5:0] load_second,
    input  logic [6:0] load_day,
    input  logic [6:0] load_month,
    input  logic [7:0] load_year,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [6:0] day,
    output logic [6:0] month,
    output logic [7:0] year,
    output logic [5:0] hour_disp,
    output logic       pm,
    output logic       sec_tick,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       hour_q, hour_d;
    logic [5:0]       minute_q, minute_d;
    logic [5:0]       second_q, second_d;
    logic [6:0]       day_q, day_d;
    logic [6:0]       month_q, month_d;
    logic [7:0]       year_q, year_d;
    logic             sec_tick_q, sec_tick_d;
    logic             load_err_q, load_err_d;

    logic             tick;
    logic             load_ok;

    // Every year divisible by 4 in 2000..2099 is a leap year (2000 included).
    function automatic logic [6:0] days_in_month(input logic [6:0] m, input logic [7:0] y);
        case (m)
            7'd4, 7'd6, 7'd9, 7'd11: days_in_month = 7'd30;
            7'd2:                    days_in_month = (y[1:0] == 2'b00) ? 7'd29 : 7'd28;
            default:                 days_in_month = 7'd31;
        endcase
    endfunction

    always_comb begin
        tick    = run && (cnt_q == CNT_LAST);
        // The day is validated against the month/year being loaded, not the stored date.
        load_ok = (load_hour <= 6'd23) && (load_minute <= 6'd59) && (load_second <= 6'd59) &&
                  (load_month >= 7'd1) && (load_month <= 7'd12) && (load_year <= 8'd99) &&
                  (load_day >= 7'd1) && (load_day <= days_in_month(load_month, load_year));
    end

    always_comb begin
        cnt_d      = cnt_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        sec_tick_d = tick && !load;
        load_err_d = load && !load_ok;

        if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        // Carry chain. Each field wraps only when every field below it wraps.
        if (tick && !load) begin
            if (second_q == 6'd59) begin
                second_d = 6'd0;
                if (minute_q == 6'd59) begin
                    minute_d = 6'd0;
                    if (hour_q == 6'd23) begin
                        hour_d = 6'd0;
                        if (day_q == days_in_month(month_q, year_q)) begin
                            day_d = 7'd1;
                            if (month_q == 7'd12) begin
                                month_d = 7'd1;
                                year_d  = (year_q == 8'd99) ? 8'd0 : year_q + 8'd1;
                            end else begin
                                month_d = month_q + 7'd1;
                            end
                        end else begin
                            day_d = day_q + 7'd1;
                        end
                    end else begin
                        hour_d = hour_q + 6'd1;
                    end
                end else begin
                    minute_d = minute_q + 6'd1;
                end
            end else begin
                second_d = second_q + 6'd1;
            end
        end

        if (load && load_ok) begin
            cnt_d    = '0;
            hour_d   = load_hour;
            minute_d = load_minute;
            second_d = load_second;
            day_d    = load_day;
            month_d  = load_month;
            year_d   = load_year;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hour_q     <= 6'd0;
            minute_q   <= 6'd0;
            second_q   <= 6'd0;
            day_q      <= 7'd1;
            month_q    <= 7'd1;
            year_q     <= 8'd0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    // 12-hour formatting: 0 shows as 12 AM, 12 as 12 PM, 13..23 as 1..11 PM.
    always_comb begin
        hour_disp = hour_q;
        pm        = 1'b0;
        if (mode_12hr) begin
            if (hour_q == 6'd0) begin
                hour_disp = 6'd12;
            end else if (hour_q > 6'd12) begin
                hour_disp = hour_q - 6'd12;
            end
            pm = (hour_q >= 6'd12);
        end
    end

    assign hour     = hour_q;
    assign minute   = minute_q;
    assign second   = second_q;
    assign day      = day_q;
    assign month    = month_q;
    assign year     = year_q;
    assign sec_tick = sec_tick_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_time_date_counter.sv
module tb_time_date_counter;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       mode_12hr = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_hour = 6'd0;
    logic [5:0] load_minute = 6'd0;
    logic [5:0] load_second = 6'd0;
    logic [6:0] load_day = 7'd1;
    logic [6:0] load_month = 7'd1;
    logic [7:0] load_year = 8'd0;
    logic [5:0] hour, minute, second, hour_disp;
    logic [6:0] day, month;
    logic [7:0] year;
    logic       pm, sec_tick, load_err;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: time of day kept as seconds since midnight.
    int m_sod = 0, m_day = 1, m_month = 1, m_year = 0, m_pre = 0;
    bit m_sec_tick = 0, m_load_err = 0;
    bit m_tk, m_ok;

    time_date_counter #(.CLKS_PER_SEC(CPS), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_12hr(mode_12hr), .load(load),
        .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .hour(hour), .minute(minute), .second(second), .day(day), .month(month),
        .year(year), .hour_disp(hour_disp), .pm(pm), .sec_tick(sec_tick), .load_err(load_err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic int month_len(input int mo, input int yr);
        int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo < 1 || mo > 12) return 0;
        if (mo == 2 && (yr % 4) == 0) return 29;
        return tab[mo - 1];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sod = 0; m_day = 1; m_month = 1; m_year = 0; m_pre = 0;
            m_sec_tick = 0; m_load_err = 0;
        end else begin
            m_tk = run && (m_pre == CPS - 1);
            m_ok = (int'(load_hour) < 24) && (int'(load_minute) < 60) && (int'(load_second) < 60) &&
                   (int'(load_year) < 100) && (int'(load_day) >= 1) &&
                   (int'(load_day) <= month_len(int'(load_month), int'(load_year)));
            m_sec_tick = m_tk && !load;
            m_load_err = load && !m_ok;
            if (load && m_ok) begin
                m_sod   = int'(load_hour) * 3600 + int'(load_minute) * 60 + int'(load_second);
                m_day   = int'(load_day);
                m_month = int'(load_month);
                m_year  = int'(load_year);
                m_pre   = 0;
            end else begin
                if (run) m_pre = (m_pre + 1) % CPS;
                if (m_tk && !load) begin
                    m_sod++;
                    if (m_sod == 86400) begin
                        m_sod = 0;
                        m_day++;
                        if (m_day > month_len(m_month, m_year)) begin
                            m_day = 1;
                            m_month++;
                            if (m_month > 12) begin
                                m_month = 1;
                                m_year = (m_year + 1) % 100;
                            end
                        end
                    end
                end
            end
        end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            int h;
            h = m_sod / 3600;
            check("hour", hour, h);
            check("minute", minute, (m_sod / 60) % 60);
            check("second", second, m_sod % 60);
            check("day", day, m_day);
            check("month", month, m_month);
            check("year", year, m_year);
            check("hour_disp", hour_disp, mode_12hr ? ((h % 12 == 0) ? 12 : h % 12) : h);
            check("pm", pm, (mode_12hr && h >= 12) ? 1 : 0);
            check("sec_tick", sec_tick, m_sec_tick);
            check("load_err", load_err, m_load_err);
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int h, input int mi, input int s, input int d, input int mo, input int y);
        load_hour = 6'(h); load_minute = 6'(mi); load_second = 6'(s);
        load_day = 7'(d); load_month = 7'(mo); load_year = 8'(y);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic load_tick(input int h, input int mi, input int s, input int d, input int mo, input int y);
        do_load(h, mi, s, d, mo, y);
        cyc(CPS);
    endtask

    task automatic summary;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        summary();
        $finish;
    end

    initial begin
        int hrs[5]  = '{0, 11, 12, 13, 23};
        int disp[5] = '{12, 11, 12, 1, 11};
        int pms[5]  = '{0, 0, 1, 1, 1};
        int nt;

        cyc(3);
        chk_en = 1'b1;
        check("rst_hour", hour, 0);
        check("rst_day", day, 1);
        check("rst_month", month, 1);
        check("rst_sec_tick", sec_tick, 0);

        // 1: first tick 4 clocks after release, then every 4
        rst_n = 1'b1;
        run = 1'b1;
        cyc(3);
        check("t1_pre_tick", sec_tick, 0);
        check("t1_pre_sec", second, 0);
        cyc(1);
        check("t1_tick", sec_tick, 1);
        check("t1_sec", second, 1);
        cyc(1);
        check("t1_tick_drop", sec_tick, 0);
        cyc(3);
        check("t1_tick2", sec_tick, 1);
        check("t1_sec2", second, 2);

        // 2: full rollover, then freeze
        do_load(23, 59, 59, 31, 12, 99);
        check("ld_hour", hour, 23);
        check("ld_year", year, 99);
        cyc(CPS);
        check("roll_tick", sec_tick, 1);
        check("roll_hour", hour, 0);
        check("roll_min", minute, 0);
        check("roll_day", day, 1);
        check("roll_month", month, 1);
        check("roll_year", year, 0);
        run = 1'b0;
        nt = 0;
        repeat (20) begin
            cyc(1);
            if (sec_tick) nt++;
        end
        check("frozen_ticks", nt, 0);
        check("frozen_sec", second, 0);
        run = 1'b1;

        // 3: month-length boundaries
        load_tick(23, 59, 59, 28, 2, 24);
        check("leap_day", day, 29);
        check("leap_month", month, 2);
        load_tick(23, 59, 59, 28, 2, 23);
        check("nonleap_day", day, 1);
        check("nonleap_month", month, 3);
        load_tick(23, 59, 59, 30, 4, 10);
        check("apr_day", day, 1);
        check("apr_month", month, 5);
        check("apr_year", year, 10);

        // 4: rejected loads
        do_load(24, 0, 0, 1, 1, 0);
        check("err_hour24", load_err, 1);
        check("err_keep_month", month, 5);
        cyc(1);
        check("err_drop", load_err, 0);
        do_load(0, 0, 0, 31, 6, 10);
        check("err_jun31", load_err, 1);
        do_load(0, 0, 0, 29, 2, 1);
        check("err_feb29", load_err, 1);
        do_load(0, 0, 0, 1, 0, 10);
        check("err_month0", load_err, 1);
        check("err_keep_day", day, 1);
        check("err_keep_year", year, 10);

        // 5: 12-hour formatting
        mode_12hr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_load(hrs[i], 30, 0, 1, 1, 0);
            check("disp12", hour_disp, disp[i]);
            check("pm12", pm, pms[i]);
        end
        do_load(13, 0, 0, 1, 1, 0);
        mode_12hr = 1'b0;
        #1;
        check("disp24", hour_disp, 13);
        check("pm24", pm, 0);
        check("hour_kept", hour, 13);

        // 6: load coincident with tick, then reset mid-count
        do_load(10, 20, 30, 15, 7, 5);
        cyc(CPS - 1);
        do_load(1, 2, 3, 4, 5, 6);
        check("coin_tick", sec_tick, 0);
        check("coin_sec", second, 3);
        check("coin_hour", hour, 1);
        cyc(CPS - 1);
        check("coin_no_tick", sec_tick, 0);
        cyc(1);
        check("coin_next_tick", sec_tick, 1);
        check("coin_next_sec", second, 4);
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hour", hour, 0);
        check("mid_rst_sec", second, 0);
        check("mid_rst_day", day, 1);
        check("mid_rst_month", month, 1);
        check("mid_rst_year", year, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(CPS - 1);
        check("rst_restart_none", sec_tick, 0);
        cyc(1);
        check("rst_restart_tick", sec_tick, 1);
        check("rst_restart_sec", second, 1);

        // random phase
        repeat (3000) begin
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                if ($urandom_range(0, 1) == 1) begin
                    load_hour   = 6'($urandom_range(22, 23));
                    load_minute = 6'($urandom_range(58, 59));
                    load_second = 6'($urandom_range(56, 59));
                    load_day    = 7'($urandom_range(26, 31));
                    load_month  = 7'($urandom_range(1, 12));
                    load_year   = 8'($urandom_range(0, 99));
                end else begin
                    load_hour   = 6'($urandom_range(0, 25));
                    load_minute = 6'($urandom_range(0, 61));
                    load_second = 6'($urandom_range(0, 61));
                    load_day    = 7'($urandom_range(0, 32));
                    load_month  = 7'($urandom_range(0, 13));
                    load_year   = 8'($urandom_range(0, 101));
                end
            end
            run = ($urandom_range(0, 9) != 0);
            mode_12hr = 1'($urandom_range(0, 1));
            cyc(1);
        end
        load = 1'b0;
        cyc(2);
        chk_en = 1'b0;
        summary();
        $finish;
    end

endmodule
